sm_acc_pipe: RTL

Pipelined, parametrised sign-magnitude adder and accumulator for the ECG accelerator datapath. It replaces the combinational 16-bit true-code adder where results must be registered, saturated or accumulated over a frame. It sits between the MAC/partial-sum stages and the activation/requantisation stage, with valid/ready handshakes on both sides.

---
 rtl/sm_pkg.sv | 70 +++++++
 rtl/sm_acc_core.sv | 132 +++++++++++++
 rtl/sm_acc_pipe.sv | 99 +++++++++
 3 files changed

// File: rtl/sm_pkg.sv
// sm_pkg -- shared types and helpers for the sign-magnitude adder/accumulator.
//
// Contents:
//   XW            working width of the width-generic helper functions
//   DW_DEF        default operand width
//   CNT_W_DEF     default frame counter width
//   MAX_MAG_DEF   largest magnitude representable at DW_DEF
//   acc_w()       accumulator width derivation (DW + CNT_W + 1)
//   max_mag()     largest magnitude at a given sign-magnitude width
//   sm2tc()       sign-magnitude -> two's complement, negative zero squashed
//   tc2sm_sat()   two's complement -> saturated sign-magnitude plus clamp flag
//
// The helpers work on XW-bit vectors with the real width passed as an
// argument, so callers zero/sign-extend into XW bits and cast the result
// back down. XW must be at least DW+CNT_W+1.
package sm_pkg;

  localparam int XW          = 64;
  localparam int DW_DEF      = 16;
  localparam int CNT_W_DEF   = 8;
  localparam int MAX_MAG_DEF = (1 << (DW_DEF - 1)) - 1;

  typedef struct packed {
    logic          ovf;
    logic [XW-1:0] sm;
  } sat_res_t;

  function automatic int acc_w(input int dw, input int cnt_w);
    return dw + cnt_w + 1;
  endfunction

  function automatic logic [XW-1:0] max_mag(input int dw);
    return (XW'(1) << (dw - 1)) - XW'(1);
  endfunction

  // sm is the zero-extended sign-magnitude value; result is two's complement
  // at XW bits. Sign=1 with magnitude 0 comes out as plain zero.
  function automatic logic [XW-1:0] sm2tc(input logic [XW-1:0] sm, input int dw);
    logic [XW-1:0] mag;
    logic          neg;
    mag = sm & max_mag(dw);
    neg = |(sm & (XW'(1) << (dw - 1)));
    return (neg && (mag != '0)) ? -mag : mag;
  endfunction

  // v is a sign-extended two's complement value. Values outside
  // +/-(2^(dw-1)-1) clamp to max magnitude with ovf set. Zero is always
  // all-zeros because only strictly negative values get the sign bit.
  function automatic sat_res_t tc2sm_sat(input logic [XW-1:0] v, input int dw);
    sat_res_t      r;
    logic [XW-1:0] mx;
    logic [XW-1:0] sb;
    mx    = max_mag(dw);
    sb    = XW'(1) << (dw - 1);
    r.ovf = 1'b0;
    if ($signed(v) > $signed(mx)) begin
      r.sm  = mx;
      r.ovf = 1'b1;
    end else if ($signed(v) < -$signed(mx)) begin
      r.sm  = sb | mx;
      r.ovf = 1'b1;
    end else if (v[XW-1]) begin
      r.sm = sb | (-v);
    end else begin
      r.sm = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/sm_acc_core.sv
// sm_acc_core -- stage 2 of sm_acc_pipe: frame accumulator and output register.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   en               global pipeline enable; all state holds when low
//   s1_valid         stage-1 register holds a beat
//   s1_sum           stage-1 sum a+b, two's complement, ACC_W bits
//   s1_mode          0 = pair add, 1 = accumulate beat
//   s1_last          closes the accumulate frame (already masked for pair beats)
//   out_valid        output register holds a result
//   out_data         saturated sign-magnitude result
//   out_ovf          result clamped (final saturation, acc clamp or long frame)
//   out_cnt          beats in the closed frame, 1 for pair beats
module sm_acc_core
  import sm_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CNT_W = 8,
  parameter int ACC_W = DW + CNT_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             s1_valid,
  input  logic [ACC_W-1:0] s1_sum,
  input  logic             s1_mode,
  input  logic             s1_last,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_open_q, frame_open_d;
  logic             frame_ovf_q, frame_ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic [ACC_W:0]   acc_sum;
  logic             acc_clip;
  logic [ACC_W-1:0] acc_next;
  logic             cnt_max;
  logic [CNT_W-1:0] cnt_inc;
  sat_res_t         pair_res;
  sat_res_t         last_res;

  always_comb begin
    // One guard bit detects the acc clamp: the two top bits differ on overflow.
    acc_sum  = {acc_q[ACC_W-1], acc_q} + {s1_sum[ACC_W-1], s1_sum};
    acc_clip = acc_sum[ACC_W] != acc_sum[ACC_W-1];
    if (acc_clip) acc_next = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    else          acc_next = acc_sum[ACC_W-1:0];
    // cnt already at max means this beat makes the frame too long.
    cnt_max  = &cnt_q;
    cnt_inc  = cnt_max ? cnt_q : cnt_q + CNT_W'(1);
    pair_res = tc2sm_sat(XW'($signed(s1_sum)), DW);
    last_res = tc2sm_sat(XW'($signed(acc_next)), DW);
  end

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    frame_open_d = frame_open_q;
    frame_ovf_d  = frame_ovf_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ovf_d    = out_ovf_q;
    out_cnt_d    = out_cnt_q;
    if (en) begin
      // An advancing pipeline retires the current result; a non-last beat
      // passes through here without producing a new one.
      out_valid_d = 1'b0;
      if (s1_valid) begin
        if (!s1_mode) begin
          out_valid_d = 1'b1;
          out_data_d  = DW'(pair_res.sm);
          out_ovf_d   = pair_res.ovf;
          out_cnt_d   = CNT_W'(1);
        end else if (!s1_last) begin
          acc_d        = acc_next;
          cnt_d        = cnt_inc;
          frame_open_d = 1'b1;
          frame_ovf_d  = frame_ovf_q | acc_clip | cnt_max;
        end else begin
          out_valid_d  = 1'b1;
          out_data_d   = DW'(last_res.sm);
          out_ovf_d    = last_res.ovf | frame_ovf_q | acc_clip | cnt_max;
          out_cnt_d    = cnt_inc;
          acc_d        = '0;
          cnt_d        = '0;
          frame_open_d = 1'b0;
          frame_ovf_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      frame_open_q <= 1'b0;
      frame_ovf_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ovf_q    <= 1'b0;
      out_cnt_q    <= '0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      frame_open_q <= frame_open_d;
      frame_ovf_q  <= frame_ovf_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ovf_q    <= out_ovf_d;
      out_cnt_q    <= out_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_cnt   = out_cnt_q;

endmodule

// File: rtl/sm_acc_pipe.sv
// sm_acc_pipe -- pipelined sign-magnitude adder / frame accumulator.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    input handshake
//   in_a, in_b            sign-magnitude operands (DW bits)
//   in_mode               0 = pair add, 1 = accumulate beat
//   in_last               closes an accumulate frame, ignored for pair beats
//   out_valid, out_ready  output handshake
//   out_data              saturated sign-magnitude result
//   out_ovf               result was clamped
//   out_cnt               beats in the closed frame, 1 for pair beats
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high; valid must not depend on ready. The whole pipe advances together on
// en = !out_valid || out_ready, so in_ready is combinational from out_ready,
// and an output transfer and an input transfer may share one edge.
//
// Pipeline: this level converts the operands and registers their sum
// (stage 1); sm_acc_core holds the accumulator and output register (stage 2).
module sm_acc_pipe
  import sm_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  input  logic             in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int ACC_W = acc_w(DW, CNT_W);

  logic             en;
  logic             s1_valid_q, s1_valid_d;
  logic [ACC_W-1:0] s1_sum_q, s1_sum_d;
  logic             s1_mode_q, s1_mode_d;
  logic             s1_last_q, s1_last_d;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_mode_d  = s1_mode_q;
    s1_last_d  = s1_last_q;
    if (en) begin
      s1_valid_d = in_valid;
      // Operands fit in DW bits, so their sum cannot overflow ACC_W bits.
      s1_sum_d   = ACC_W'(sm2tc(XW'(in_a), DW) + sm2tc(XW'(in_b), DW));
      s1_mode_d  = in_mode;
      s1_last_d  = in_last & in_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_mode_q  <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_mode_q  <= s1_mode_d;
      s1_last_q  <= s1_last_d;
    end
  end

  sm_acc_core #(
    .DW    (DW),
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .s1_valid  (s1_valid_q),
    .s1_sum    (s1_sum_q),
    .s1_mode   (s1_mode_q),
    .s1_last   (s1_last_q),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_cnt   (out_cnt)
  );

endmodule
